// File: rtl/aes128_round_sequencer_if.sv
// Host-side handshake bundle for aes128_round_sequencer: block input and ciphertext output.
// slave = the sequencer, master = the host that supplies blocks and consumes results.
interface aes128_round_sequencer_if ();
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one round per cycle, on-the-fly key schedule, 10 rounds per block.
// Optional feature: define AES_ABORT_EN to add the abort input that cancels an in-flight block.
module aes128_round_sequencer (
  input  logic                     clk,
  input  logic                     rst,
  aes128_round_sequencer_if.slave  bus,
  output logic                     busy,
  output logic [3:0]               round
`ifdef AES_ABORT_EN
  ,
  input  logic                     abort
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bytes are column-major: byte (4*c + r) sits at [127-8*(4*c+r) -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] nk, sr, mc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    nk = key_step(rk_q, rcon(rnd_q));
    sr = sub_shift(state_q);
    mc = mix_columns(sr);
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.plaintext ^ bus.key;
          rk_d    = bus.key;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        // Out-of-range round counts can only come from upsets; drop the block.
        if (rnd_q == 4'd0 || rnd_q > 4'd10) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end else begin
          state_d = ((rnd_q == 4'd10) ? sr : mc) ^ nk;
          rk_d    = nk;
          if (rnd_q == 4'd10) fsm_d = DONE;
          else                rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = '0;
      end
    endcase
`ifdef AES_ABORT_EN
    // Abort outranks the output handshake; datapath registers are left as they are.
    if (abort && fsm_q != IDLE) begin
      fsm_d   = IDLE;
      rnd_d   = '0;
      state_d = state_q;
      rk_d    = rk_q;
    end
`endif
  end

  assign bus.in_ready   = (fsm_q == IDLE);
  assign bus.out_valid  = (fsm_q == DONE);
  assign bus.ciphertext = state_q;
  assign busy           = (fsm_q == ROUND) || (fsm_q == DONE);
  assign round          = rnd_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Directed bench for aes128_round_sequencer: known-answer vectors plus handshake corner cases.
// Define AES_ABORT_EN to also exercise the abort input.
module tb_aes128_round_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] round;
`ifdef AES_ABORT_EN
  logic       abort;
`endif

  always #5 clk = ~clk;

  aes128_round_sequencer_if bus ();

  aes128_round_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .round (round)
`ifdef AES_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[3];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block from a post-edge point; returns one step after the accept edge.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    int w;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) chk("accept_timeout", 128'(w), 128'd0);
    bus.in_valid  = 1'b1;
    bus.plaintext = pt;
    bus.key       = key;
    tick();
    bus.in_valid  = 1'b0;
    bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
    bus.key       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   128'(bus.in_ready),  128'd1);
    chk({tag, "_out_valid"},  128'(bus.out_valid), 128'd0);
    chk({tag, "_busy"},       128'(busy),          128'd0);
    chk({tag, "_round"},      128'(round),         128'd0);
    chk({tag, "_ciphertext"}, bus.ciphertext,      128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          cyc, n_acc, n_out, bad, w;
    int          acc[4];
    int          oc[2];
    logic [127:0] outs[2];
    bit          seen;

    vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
`ifdef AES_ABORT_EN
    abort         = 1'b0;
`endif
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      accept(vecs[i].pt, vecs[i].key);
      wait_done(lat);
      chk($sformatf("vec%0d_ct", i), bus.ciphertext, vecs[i].ct);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd10);
      handshake();
      chk($sformatf("vec%0d_idle_ready", i), 128'(bus.in_ready), 128'd1);
      chk($sformatf("vec%0d_idle_round", i), 128'(round), 128'd0);
    end

    // Round index steps 1..10 on consecutive cycles.
    accept(vecs[1].pt, vecs[1].key);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("c1_round%0d", k), 128'(round), 128'(k));
      tick();
    end
    chk("c1_out_valid", 128'(bus.out_valid), 128'd1);
    chk("c1_ct", bus.ciphertext, vecs[1].ct);
    handshake();

    // Backpressure: DONE held for 20 cycles.
    accept(vecs[0].pt, vecs[0].key);
    wait_done(lat);
    chk("bp_latency", 128'(lat), 128'd10);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.ciphertext !== vecs[0].ct || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
      tick();
    end
    chk("bp_stable_cycles_bad", 128'(bad), 128'd0);
    handshake();
    chk("bp_release_ready", 128'(bus.in_ready), 128'd1);
    chk("bp_release_valid", 128'(bus.out_valid), 128'd0);

    // Back-to-back with in_valid held and out_ready held.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.plaintext = vecs[0].pt;
    bus.key       = vecs[0].key;
    cyc = 0; n_acc = 0; n_out = 0;
    while (n_out < 2 && cyc < 60) begin
      if (bus.in_ready && bus.in_valid) begin
        if (n_acc < 4) acc[n_acc] = cyc;
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        outs[n_out] = bus.ciphertext;
        oc[n_out]   = cyc;
        n_out++;
      end
      tick();
      cyc++;
      if (n_acc == 1) begin
        bus.plaintext = vecs[1].pt;
        bus.key       = vecs[1].key;
      end
      if (n_acc >= 2) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_outputs", 128'(n_out), 128'd2);
    chk("b2b_accepts", 128'(n_acc), 128'd2);
    if (n_out == 2 && n_acc == 2) begin
      chk("b2b_ct0", outs[0], vecs[0].ct);
      chk("b2b_ct1", outs[1], vecs[1].ct);
      chk("b2b_period", 128'(oc[1] - oc[0]), 128'd12);
      chk("b2b_second_accept", 128'(acc[1]), 128'(oc[0] + 1));
    end

    // Asynchronous reset at round 5.
    accept(vecs[2].pt, vecs[2].key);
    w = 0;
    while (round != 4'd5 && w < 20) begin
      tick();
      w++;
    end
    chk("ar_reach_round5", 128'(round), 128'd5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("ar_no_out_valid", 128'(seen), 128'd0);
    accept(vecs[0].pt, vecs[0].key);
    wait_done(lat);
    chk("ar_after_ct", bus.ciphertext, vecs[0].ct);
    chk("ar_after_latency", 128'(lat), 128'd10);
    handshake();

`ifdef AES_ABORT_EN
    accept(vecs[1].pt, vecs[1].key);
    w = 0;
    while (round != 4'd3 && w < 20) begin
      tick();
      w++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_round_idle", 128'(bus.in_ready), 128'd1);
    chk("ab_round_rnd", 128'(round), 128'd0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("ab_no_out_valid", 128'(seen), 128'd0);

    accept(vecs[0].pt, vecs[0].key);
    wait_done(lat);
    chk("ab_done_reached", 128'(bus.out_valid), 128'd1);
    abort         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    abort         = 1'b0;
    bus.out_ready = 1'b0;
    chk("ab_done_idle", 128'(bus.in_ready), 128'd1);
    chk("ab_done_valid", 128'(bus.out_valid), 128'd0);

    // Abort in IDLE together with in_valid still accepts.
    abort = 1'b1;
    accept(vecs[2].pt, vecs[2].key);
    abort = 1'b0;
    chk("ab_idle_accept", 128'(busy), 128'd1);
    wait_done(lat);
    chk("ab_idle_ct", bus.ciphertext, vecs[2].ct);
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
